// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR generator/checker pair.
// The tap set lives only here, so both ends always agree.
package lfsr_pkg;
  localparam int LFSR_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 6;
  localparam int TAP_C  = 5;
  localparam int TAP_D  = 1;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'hAEAF696C;

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} lfsr_state_e;

  function automatic logic lfsr_next(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        r_count <= '0;
    else if (i_clear)                  r_count <= '0;
    else if (i_inc && (r_count != '1)) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: hunts for a valid LFSR state, verifies it,
// then free-runs a local copy and counts line errors while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 256,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  localparam int FILL_W  = $clog2(LFSR_W);
  localparam int MATCH_W = $clog2(LOCK_CNT);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(ERR_THRESH);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(ERR_THRESH - 1);

  lfsr_state_e         r_state;
  logic [LFSR_W-1:0]   r_s;
  logic [FILL_W-1:0]   r_fill;
  logic [MATCH_W-1:0]  r_match;
  logic [WIN_W-1:0]    r_win;
  logic [WERR_W-1:0]   r_werr;
  logic                r_locked;
  logic                r_err_pulse;

  logic                w_exp;
  logic                w_miss;
  logic                w_lk_acc;
  logic                w_err;
  logic [LFSR_W-1:0]   w_shift_in;

  assign w_exp      = lfsr_next(r_s);
  assign w_miss     = in_bit ^ w_exp;
  assign w_lk_acc   = in_valid & (r_state == ST_LOCKED);
  assign w_err      = w_lk_acc & w_miss;
  assign w_shift_in = {r_s[LFSR_W-2:0], in_bit};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_s         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (in_valid) begin
        case (r_state)
          ST_HUNT: begin
            r_s    <= w_shift_in;
            r_fill <= r_fill + 1'b1;
            // An all-zero load is the LFSR lock-up state; keep hunting.
            if (r_fill == FILL_LAST) begin
              r_fill <= '0;
              if (w_shift_in != '0) begin
                r_state <= ST_VERIFY;
                r_match <= '0;
              end
            end
          end
          ST_VERIFY: begin
            r_s <= w_shift_in;
            if (!w_miss) begin
              r_match <= r_match + 1'b1;
              if (r_match == MATCH_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_win    <= '0;
                r_werr   <= '0;
              end
            end else begin
              r_state <= ST_HUNT;
              r_fill  <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-run on our own prediction so a line error is counted once.
            r_s <= {r_s[LFSR_W-2:0], w_exp};
            if (w_miss && (r_werr == WERR_LAST)) begin
              r_state  <= ST_HUNT;
              r_locked <= 1'b0;
              r_fill   <= '0;
            end else begin
              r_werr <= r_werr + WERR_W'(w_miss);
              if (r_win == WIN_LAST) begin
                r_win  <= '0;
                r_werr <= '0;
              end else begin
                r_win <= r_win + 1'b1;
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (clear),
    .i_inc   (w_err),
    .o_count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (clear),
    .i_inc   (w_lk_acc),
    .o_count (bit_count)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
endmodule
